// File: rtl/rename_reg_file_pkg.sv
// Shared constants and helpers for the rename register file.
// Widths, zero register/tag constants and the commit tag-match test.
package rename_reg_file_pkg;

   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int REG_W = $clog2(NREG);
   localparam int ROB_W = 4;
   localparam int NRD   = 2;

   localparam logic [REG_W-1:0] ZERO_REG  = {REG_W{1'b0}};
   localparam logic [ROB_W-1:0] ZERO_ROB  = {ROB_W{1'b0}};
   localparam logic [XLEN-1:0]  ZERO_DATA = {XLEN{1'b0}};
   localparam logic             TRUE      = 1'b1;
   localparam logic             FALSE     = 1'b0;

   // A commit retires a rename only if the register still waits on that exact ROB entry.
   function automatic logic tag_hit(input logic busy,
                                    input logic [ROB_W-1:0] tag,
                                    input logic [ROB_W-1:0] cmt_tag);
      return busy && (tag == cmt_tag);
   endfunction

endpackage

// File: rtl/rename_reg_file_entry.sv
// One architectural register: value plus rename tag and busy flag.
// State priority: rst > flush > rename > commit-clear; the value write is independent.
module rename_reg_entry
   import rename_reg_file_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [XLEN-1:0]  wr_value,
   input  logic             ren_en,
   input  logic [ROB_W-1:0] ren_tag,
   input  logic             clr_tag_match,
   input  logic             flush,
   output logic [XLEN-1:0]  value,
   output logic [ROB_W-1:0] tag,
   output logic             busy
);

   logic [XLEN-1:0]  value_r;
   logic [ROB_W-1:0] tag_r;
   logic             busy_r;

   // Per-register value, tag and busy state.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_r <= ZERO_DATA;
         tag_r   <= ZERO_ROB;
         busy_r  <= FALSE;
      end else begin
         if (wr_en) begin
            value_r <= wr_value;
         end
         if (flush) begin
            tag_r  <= ZERO_ROB;
            busy_r <= FALSE;
         end else if (ren_en) begin
            tag_r  <= ren_tag;
            busy_r <= TRUE;
         end else if (clr_tag_match) begin
            tag_r  <= ZERO_ROB;
            busy_r <= FALSE;
         end
      end
   end

   assign value = value_r;
   assign tag   = tag_r;
   assign busy  = busy_r;

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with rename tags, combinational read ports and commit bypass.
// Entry 0 is hardwired to zero; entries 1..NREG-1 are rename_reg_entry instances.
module rename_reg_file
   import rename_reg_file_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NRD*REG_W-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0]    rd_value,
   output logic [NRD*ROB_W-1:0]   rd_tag,
   output logic [NRD-1:0]         rd_busy,
   input  logic                   ren_en,
   input  logic [REG_W-1:0]       ren_reg,
   input  logic [ROB_W-1:0]       ren_tag,
   input  logic                   cmt_en,
   input  logic [REG_W-1:0]       cmt_reg,
   input  logic [ROB_W-1:0]       cmt_tag,
   input  logic [XLEN-1:0]        cmt_value,
   input  logic                   flush
);

   logic [XLEN-1:0]  value_s [NREG];
   logic [ROB_W-1:0] tag_s   [NREG];
   logic             busy_s  [NREG];

   assign value_s[0] = ZERO_DATA;
   assign tag_s[0]   = ZERO_ROB;
   assign busy_s[0]  = FALSE;

   for (genvar i = 1; i < NREG; i++) begin : g_entry
      logic wr_s;
      logic ren_s;
      logic clr_s;

      assign wr_s  = cmt_en && (cmt_reg == REG_W'(i));
      assign ren_s = ren_en && (ren_reg == REG_W'(i));
      assign clr_s = wr_s && tag_hit(busy_s[i], tag_s[i], cmt_tag);

      rename_reg_entry u_entry (
         .clk           (clk),
         .rst           (rst),
         .wr_en         (wr_s),
         .wr_value      (cmt_value),
         .ren_en        (ren_s),
         .ren_tag       (ren_tag),
         .clr_tag_match (clr_s),
         .flush         (flush),
         .value         (value_s[i]),
         .tag           (tag_s[i]),
         .busy          (busy_s[i])
      );
   end

   logic [REG_W-1:0] addr_s;

   // Read muxes; a retiring commit to the awaited tag is forwarded in the same cycle.
   always_comb begin
      rd_value = {(NRD*XLEN){1'b0}};
      rd_tag   = {(NRD*ROB_W){1'b0}};
      rd_busy  = {NRD{1'b0}};
      addr_s   = ZERO_REG;
      for (int p = 0; p < NRD; p++) begin
         addr_s = rd_addr[p*REG_W +: REG_W];
         if (cmt_en && (cmt_reg == addr_s) && (addr_s != ZERO_REG) &&
             tag_hit(busy_s[addr_s], tag_s[addr_s], cmt_tag)) begin
            rd_value[p*XLEN +: XLEN]   = cmt_value;
            rd_tag[p*ROB_W +: ROB_W]   = ZERO_ROB;
            rd_busy[p]                 = FALSE;
         end else begin
            rd_value[p*XLEN +: XLEN]   = value_s[addr_s];
            rd_tag[p*ROB_W +: ROB_W]   = tag_s[addr_s];
            rd_busy[p]                 = busy_s[addr_s];
         end
      end
   end

endmodule

// File: tb/tb_rename_reg_file.sv
// Scoreboard bench for rename_reg_file: stimulus pushes expected read results,
// a negedge monitor pops and compares them against the read ports.
module tb_rename_reg_file;
   import rename_reg_file_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NRD*REG_W-1:0]  rd_addr;
   logic [NRD*XLEN-1:0]   rd_value;
   logic [NRD*ROB_W-1:0]  rd_tag;
   logic [NRD-1:0]        rd_busy;
   logic                  ren_en;
   logic [REG_W-1:0]      ren_reg;
   logic [ROB_W-1:0]      ren_tag;
   logic                  cmt_en;
   logic [REG_W-1:0]      cmt_reg;
   logic [ROB_W-1:0]      cmt_tag;
   logic [XLEN-1:0]       cmt_value;
   logic                  flush;
   logic                  sample_en;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string            nm;
      int               port;
      logic [XLEN-1:0]  v;
      logic [ROB_W-1:0] t;
      logic             b;
   } exp_t;

   exp_t exp_q[$];

   rename_reg_file dut (
      .clk       (clk),
      .rst       (rst),
      .rd_addr   (rd_addr),
      .rd_value  (rd_value),
      .rd_tag    (rd_tag),
      .rd_busy   (rd_busy),
      .ren_en    (ren_en),
      .ren_reg   (ren_reg),
      .ren_tag   (ren_tag),
      .cmt_en    (cmt_en),
      .cmt_reg   (cmt_reg),
      .cmt_tag   (cmt_tag),
      .cmt_value (cmt_value),
      .flush     (flush)
   );

   always #5 clk = ~clk;

   // Monitor: compare every queued expectation while a read sample is presented.
   always @(negedge clk) begin
      if (sample_en) begin
         while (exp_q.size() > 0) begin
            exp_t e;
            logic [XLEN-1:0]  av;
            logic [ROB_W-1:0] at;
            logic             ab;
            e  = exp_q.pop_front();
            av = rd_value[e.port*XLEN +: XLEN];
            at = rd_tag[e.port*ROB_W +: ROB_W];
            ab = rd_busy[e.port];
            checks++;
            if (av !== e.v || at !== e.t || ab !== e.b) begin
               errors++;
               $display("FAIL %s port%0d: got value=%h tag=%0d busy=%b, expected value=%h tag=%0d busy=%b",
                        e.nm, e.port, av, at, ab, e.v, e.t, e.b);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      rst = 1'b0; ren_en = 1'b0; cmt_en = 1'b0; flush = 1'b0; sample_en = 1'b0;
      ren_reg = 5'd0; ren_tag = 4'd0; cmt_reg = 5'd0; cmt_tag = 4'd0; cmt_value = 32'd0;
   endtask

   task automatic rd(input int port, input logic [REG_W-1:0] addr, input logic [XLEN-1:0] v,
                     input logic [ROB_W-1:0] t, input logic b, input string nm);
      exp_t e;
      rd_addr[port*REG_W +: REG_W] = addr;
      e.nm = nm; e.port = port; e.v = v; e.t = t; e.b = b;
      exp_q.push_back(e);
      sample_en = 1'b1;
   endtask

   task automatic ren(input logic [REG_W-1:0] r, input logic [ROB_W-1:0] t);
      ren_en = 1'b1; ren_reg = r; ren_tag = t;
   endtask

   task automatic cmt(input logic [REG_W-1:0] r, input logic [ROB_W-1:0] t, input logic [XLEN-1:0] v);
      cmt_en = 1'b1; cmt_reg = r; cmt_tag = t; cmt_value = v;
   endtask

   initial begin
      rst = 1'b1; rd_addr = 10'd0; sample_en = 1'b0;
      ren_en = 1'b0; ren_reg = 5'd0; ren_tag = 4'd0;
      cmt_en = 1'b0; cmt_reg = 5'd0; cmt_tag = 4'd0; cmt_value = 32'd0; flush = 1'b0;
      step();

      // 1. reset state
      rd(0, 5'd5, 32'h0, 4'd0, 1'b0, "reset_r5"); rd(1, 5'd0, 32'h0, 4'd0, 1'b0, "reset_r0"); step();

      // 2. rename, read, commit bypass, stored value
      ren(5'd3, 4'd7); rd(0, 5'd3, 32'h0, 4'd0, 1'b0, "ren_not_visible"); step();
      rd(0, 5'd3, 32'h0, 4'd7, 1'b1, "r3_busy"); step();
      cmt(5'd3, 4'd7, 32'hAB);
      rd(0, 5'd3, 32'hAB, 4'd0, 1'b0, "r3_bypass"); rd(1, 5'd5, 32'h0, 4'd0, 1'b0, "r5_no_bypass"); step();
      rd(0, 5'd3, 32'hAB, 4'd0, 1'b0, "r3_stored"); step();

      // 3. younger rename survives older commit
      ren(5'd4, 4'd2); step();
      ren(5'd4, 4'd5); rd(0, 5'd4, 32'h0, 4'd2, 1'b1, "r4_tag2"); step();
      cmt(5'd4, 4'd2, 32'h11); rd(1, 5'd4, 32'h0, 4'd5, 1'b1, "r4_no_bypass"); step();
      rd(1, 5'd4, 32'h11, 4'd5, 1'b1, "r4_after_cmt"); step();

      // 4. rename and matching commit in the same cycle
      ren(5'd6, 4'd1); step();
      cmt(5'd6, 4'd1, 32'h22); ren(5'd6, 4'd3);
      rd(0, 5'd6, 32'h22, 4'd0, 1'b0, "r6_bypass"); step();
      rd(0, 5'd6, 32'h22, 4'd3, 1'b1, "r6_ren_wins"); step();

      // 5. flush with same-cycle rename and commit
      ren(5'd1, 4'd1); step();
      ren(5'd2, 4'd2); step();
      ren(5'd9, 4'd6); step();
      rd(0, 5'd1, 32'h0, 4'd1, 1'b1, "r1_busy"); rd(1, 5'd9, 32'h0, 4'd6, 1'b1, "r9_busy"); step();
      flush = 1'b1; ren(5'd8, 4'd4); cmt(5'd1, 4'd1, 32'h33);
      rd(0, 5'd1, 32'h33, 4'd0, 1'b0, "flush_r1_bypass"); rd(1, 5'd8, 32'h0, 4'd0, 1'b0, "flush_r8_pre"); step();
      rd(0, 5'd1, 32'h33, 4'd0, 1'b0, "flush_r1"); rd(1, 5'd8, 32'h0, 4'd0, 1'b0, "flush_r8_dropped"); step();
      rd(0, 5'd2, 32'h0, 4'd0, 1'b0, "flush_r2"); rd(1, 5'd9, 32'h0, 4'd0, 1'b0, "flush_r9"); step();
      rd(0, 5'd4, 32'h11, 4'd0, 1'b0, "flush_r4"); rd(1, 5'd6, 32'h22, 4'd0, 1'b0, "flush_r6"); step();

      // 6. register 0 is immutable; reset mid-stream
      ren(5'd0, 4'd5); cmt(5'd0, 4'd0, 32'hFF); rd(0, 5'd0, 32'h0, 4'd0, 1'b0, "r0_cmt_cycle"); step();
      ren(5'd7, 4'd7); rd(0, 5'd0, 32'h0, 4'd0, 1'b0, "r0_after"); step();
      rst = 1'b1; ren(5'd10, 4'd3); cmt(5'd3, 4'd0, 32'h55);
      rd(0, 5'd0, 32'h0, 4'd0, 1'b0, "r0_rst_cycle"); rd(1, 5'd7, 32'h0, 4'd7, 1'b1, "r7_pre_rst"); step();
      rd(0, 5'd7, 32'h0, 4'd0, 1'b0, "rst_r7"); rd(1, 5'd3, 32'h0, 4'd0, 1'b0, "rst_r3"); step();
      rd(0, 5'd10, 32'h0, 4'd0, 1'b0, "rst_r10"); rd(1, 5'd1, 32'h0, 4'd0, 1'b0, "rst_r1"); step();
      rd(0, 5'd4, 32'h0, 4'd0, 1'b0, "rst_r4"); rd(1, 5'd6, 32'h0, 4'd0, 1'b0, "rst_r6"); step();
      step();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
